// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: converts decoder mem_rd/mem_wr strobes into a req/ack bus cycle and stalls the decoder.
// Optional feature: define MEM_BUS_WRITE_POST_EN for posted (non-stalling) writes.
module mem_bus_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_mem_rd,
  input  logic              i_mem_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_stall,
  output logic              o_bus_err,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [DATA_W-1:0] o_bus_wdata,
  input  logic              i_bus_ack,
  input  logic [DATA_W-1:0] i_bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                stall;
  logic                anyReq;
  logic                illegalReq;
`ifdef MEM_BUS_WRITE_POST_EN
  logic                post_q, post_d;
`endif

  assign anyReq     = i_mem_rd | i_mem_wr;
  assign illegalReq = i_mem_rd & i_mem_wr;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    stall   = 1'b0;
`ifdef MEM_BUS_WRITE_POST_EN
    post_d  = post_q;
`endif
    case (state_q)
      IDLE: begin
        if (illegalReq) begin
          err_d = 1'b1;
        end else if (anyReq) begin
          addr_d  = i_addr;
          wdata_d = i_wdata;
          we_d    = i_mem_wr;
          req_d   = 1'b1;
          cnt_d   = 8'd0;
          state_d = REQ;
          stall   = 1'b1;
`ifdef MEM_BUS_WRITE_POST_EN
          // A posted write lets the decoder run on while the bus cycle finishes.
          if (i_mem_wr) begin
            stall  = 1'b0;
            post_d = 1'b1;
          end
`endif
        end
      end
      REQ: begin
        stall = 1'b1;
`ifdef MEM_BUS_WRITE_POST_EN
        if (post_q) stall = anyReq;
`endif
        if (i_bus_ack) begin
          req_d   = 1'b0;
          cnt_d   = 8'd0;
          state_d = DONE;
          if (!we_q) rdata_d = i_bus_rdata;
`ifdef MEM_BUS_WRITE_POST_EN
          if (post_q) begin
            state_d = IDLE;
            post_d  = 1'b0;
          end
`endif
        end else if (cnt_q == CntLast) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          cnt_d   = 8'd0;
          state_d = DONE;
          rdata_d = '1;
`ifdef MEM_BUS_WRITE_POST_EN
          if (post_q) begin
            state_d = IDLE;
            post_d  = 1'b0;
            rdata_d = rdata_q;
          end
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        // The request still visible here is the one just completed; never restart it.
        cnt_d   = 8'd0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
`ifdef MEM_BUS_WRITE_POST_EN
      post_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`ifdef MEM_BUS_WRITE_POST_EN
      post_q  <= post_d;
`endif
    end
  end

  assign o_rdata     = rdata_q;
  assign o_stall     = stall;
  assign o_bus_err   = err_q;
  assign o_bus_req   = req_q;
  assign o_bus_we    = we_q;
  assign o_bus_addr  = addr_q;
  assign o_bus_wdata = wdata_q;

endmodule
